mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-requester arbiter for the single 32-bit memory port served by the SRAM/IO controller.
- Requester 0 is the CPU core; requester 1 is a secondary master (debug/DMA loader).
- Latches the winning request and drives the shared port with registered outputs.
- Returns the ack and read data to the winner only, and aborts any transaction the controller never acknowledges.

Parameters:
- PRIORITY_MODE, 0, 0 = round-robin (last winner loses ties); 1 = fixed priority (requester 0 always wins ties).
- TIMEOUT, 255, max cycles in BUSY before abort; 8-bit counter; 0 disables timeout.
- ERR_DATA, 32'hDEADBEEF, read data returned on timeout abort.

Ports:
- clk  in  1  system clock (single domain).
- reset_n  in  1  asynchronous active-low reset.
- m0_read  in  1  requester 0 read request; level, held until m0_ack.
- m0_write  in  1  requester 0 write request; level, held until m0_ack.
- m0_addr  in  32  requester 0 address.
- m0_write_data  in  32  requester 0 write data.
- m0_ack  out  1  one-cycle completion pulse to requester 0.
- m0_err  out  1  one-cycle pulse with m0_ack when the transaction timed out.
- m0_read_data  out  32  read data; valid when m0_ack=1.
- m1_read, m1_write, m1_addr, m1_write_data, m1_ack, m1_err, m1_read_data: identical to the m0_* ports, for requester 1.
- mem_read  out  1  to controller, registered.
- mem_write  out  1  to controller, registered.
- mem_addr  out  32  to controller, registered.
- mem_write_data  out  32  to controller, registered.
- mem_ack  in  1  controller completion pulse.
- mem_read_data  in  32  controller read data; valid with mem_ack.
- grant  out  2  one-hot current owner (01 = m0, 10 = m1, 00 = none); debug/LED use.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - state=IDLE; all outputs 0, including m*_read_data and grant.
  - last_winner=1, so requester 0 wins the first tie.
- A requester is pending when read|write=1. If both are set, the request is a write (read ignored).
- States:
  - IDLE
  - BUSY
  - RESP: one cycle, ack to winner.
  - RELEASE: one cycle, lets the winner drop its request.
- IDLE:
  - No pending requester: stay in IDLE.
  - Exactly one pending: it wins.
  - Both pending: PRIORITY_MODE=0 -> the requester other than last_winner wins; PRIORITY_MODE=1 -> m0 wins.
  - On a win, same edge:
    - Register addr and write_data.
    - Set mem_write=1 for a write, or mem_read=1 for a read.
    - Set grant; last_winner <= winner; timeout counter <= 0.
    - Go to BUSY.
  - Latency from request to mem_read/mem_write: 1 cycle.
- BUSY:
  - Hold mem_* stable; the counter increments each cycle.
  - mem_ack=1: capture mem_read_data into winner's read_data (writes capture too, value don't-care); clear mem_read/mem_write; go to RESP.
  - TIMEOUT!=0, counter reaches TIMEOUT, and mem_ack=0: clear mem_read/mem_write; read_data <= ERR_DATA; set err flag; go to RESP.
  - mem_ack has priority over timeout in the same cycle.
- RESP:
  - Winner's ack=1 (and err=1 if the timeout flag is set) for exactly this cycle.
  - The loser's ack is never asserted.
  - Go to RELEASE.
- RELEASE:
  - The winner's request is ignored this cycle; grant <= 00; go to IDLE.
  - Throughput: 4 cycles minimum per transaction when mem_ack arrives in the first BUSY cycle.
- m*_read_data holds its last value until the next completion for that requester.
- The requester must hold addr/data while pending; changes after grant are ignored (a snapshot is taken).
- mem_ack arriving outside BUSY (e.g. a late ack after a timeout) is ignored.
- A requester dropping its request during BUSY does not cancel the transaction; the ack is still returned.
- Reset asserted mid-transaction: immediate return to the reset values; the controller sees mem_read/mem_write drop asynchronously.

Test Plan:
- Single read: m0_read=1, m0_addr=0x10; controller acks in the 3rd BUSY cycle with 0x12345678.
  -> mem_read high 3 cycles, mem_addr=0x10; m0_ack pulse 1 cycle later with m0_read_data=0x12345678; m0_err=0; grant=01, then 00.
- Tie, round-robin (PRIORITY_MODE=0): m0_write and m1_read held continuously from reset, ack after 1 cycle each.
  -> grants alternate m0, m1, m0, m1; every 4 cycles one ack; no ack goes to the non-owner.
- Fixed priority (PRIORITY_MODE=1): same stimulus -> m0 wins every arbitration; m1 is never granted while m0 is held.
- Timeout (TIMEOUT=4): m1_read with mem_ack tied 0.
  -> mem_read drops after 4 BUSY cycles; m1_ack=m1_err=1 for one cycle; m1_read_data=0xDEADBEEF.
  -> A subsequent late mem_ack is ignored, and the next m0 request completes normally.
- Read+write both set: m0_read=m0_write=1, addr=0x20, data=0xA5A5A5A5 -> mem_write=1, mem_read=0, mem_write_data=0xA5A5A5A5.
- Reset mid-BUSY: pull reset_n low two cycles into BUSY -> mem_read, grant and acks go to 0 immediately (before the next edge).
  -> After release, the first tie goes to m0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for the shared 32-bit SRAM/IO controller port.
// The winning request is snapshotted into registers that drive the port.
// Ack and read data go back to the winner only. A transaction the
// controller never acknowledges is aborted after TIMEOUT busy cycles.
module mem_arbiter #(
  parameter int unsigned PRIORITY_MODE = 0,
  parameter int unsigned TIMEOUT       = 255,
  parameter logic [31:0] ERR_DATA      = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        m0_read,
  input  logic        m0_write,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_write_data,
  output logic        m0_ack,
  output logic        m0_err,
  output logic [31:0] m0_read_data,
  input  logic        m1_read,
  input  logic        m1_write,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_write_data,
  output logic        m1_ack,
  output logic        m1_err,
  output logic [31:0] m1_read_data,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic        mem_ack,
  input  logic [31:0] mem_read_data,
  output logic [1:0]  grant
);

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] TIMEOUT_CNT = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BUSY    = 2'd1,
    S_RESP    = 2'd2,
    S_RELEASE = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic          last_q, last_d;        // 1 = requester 1 won last
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    grant_q, grant_d;
  logic          mem_read_q, mem_read_d;
  logic          mem_write_q, mem_write_d;
  logic [DW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          m0_ack_q, m0_ack_d;
  logic          m1_ack_q, m1_ack_d;
  logic          m0_err_q, m0_err_d;
  logic          m1_err_q, m1_err_d;
  logic [DW-1:0] m0_rdata_q, m0_rdata_d;
  logic [DW-1:0] m1_rdata_q, m1_rdata_d;

  logic m0_pend;
  logic m1_pend;
  logic win_m1;
  logic done;
  logic timed_out;
  logic [DW-1:0] resp_data;

  assign m0_pend = m0_read | m0_write;
  assign m1_pend = m1_read | m1_write;

  // Next-state and next-output computation for the arbitration sequence.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    grant_d     = grant_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    m0_rdata_d  = m0_rdata_q;
    m1_rdata_d  = m1_rdata_q;
    m0_ack_d    = 1'b0;
    m1_ack_d    = 1'b0;
    m0_err_d    = 1'b0;
    m1_err_d    = 1'b0;
    win_m1      = 1'b0;
    done        = 1'b0;
    timed_out   = 1'b0;
    resp_data   = mem_read_data;

    case (state_q)
      S_IDLE: begin
        if (m0_pend || m1_pend) begin
          if (m0_pend && m1_pend) begin
            win_m1 = (PRIORITY_MODE != 0) ? 1'b0 : ~last_q;
          end else begin
            win_m1 = m1_pend;
          end
          // A request with both read and write set is treated as a write.
          if (win_m1) begin
            mem_addr_d  = m1_addr;
            mem_wdata_d = m1_write_data;
            mem_write_d = m1_write;
            mem_read_d  = m1_read & ~m1_write;
            grant_d     = 2'b10;
          end else begin
            mem_addr_d  = m0_addr;
            mem_wdata_d = m0_write_data;
            mem_write_d = m0_write;
            mem_read_d  = m0_read & ~m0_write;
            grant_d     = 2'b01;
          end
          last_d  = win_m1;
          cnt_d   = '0;
          state_d = S_BUSY;
        end
      end

      S_BUSY: begin
        cnt_d = cnt_q + CW'(1);
        if (mem_ack) begin
          done = 1'b1;
        end else if ((TIMEOUT != 0) && (cnt_d == TIMEOUT_CNT)) begin
          done      = 1'b1;
          timed_out = 1'b1;
          resp_data = ERR_DATA;
        end
        if (done) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          state_d     = S_RESP;
          if (grant_q[1]) begin
            m1_rdata_d = resp_data;
            m1_ack_d   = 1'b1;
            m1_err_d   = timed_out;
          end else begin
            m0_rdata_d = resp_data;
            m0_ack_d   = 1'b1;
            m0_err_d   = timed_out;
          end
        end
      end

      S_RESP: begin
        state_d = S_RELEASE;
      end

      S_RELEASE: begin
        grant_d = 2'b00;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; async reset returns every output to zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      last_q      <= 1'b1;
      cnt_q       <= '0;
      grant_q     <= 2'b00;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      m0_ack_q    <= 1'b0;
      m1_ack_q    <= 1'b0;
      m0_err_q    <= 1'b0;
      m1_err_q    <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      grant_q     <= grant_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      m0_ack_q    <= m0_ack_d;
      m1_ack_q    <= m1_ack_d;
      m0_err_q    <= m0_err_d;
      m1_err_q    <= m1_err_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_rdata_q  <= m1_rdata_d;
    end
  end

  assign mem_read       = mem_read_q;
  assign mem_write      = mem_write_q;
  assign mem_addr       = mem_addr_q;
  assign mem_write_data = mem_wdata_q;
  assign grant          = grant_q;
  assign m0_ack         = m0_ack_q;
  assign m1_ack         = m1_ack_q;
  assign m0_err         = m0_err_q;
  assign m1_err         = m1_err_q;
  assign m0_read_data   = m0_rdata_q;
  assign m1_read_data   = m1_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a round-robin instance (TIMEOUT=4) and a
// fixed-priority instance (timeout disabled) share the same stimulus and are
// each checked every cycle against a transaction-level model.
module tb_mem_arbiter;

  logic        clk;
  logic        reset_n;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_addr, m0_write_data, m1_addr, m1_write_data;
  logic        mem_ack;
  logic [31:0] mem_read_data;

  wire [1:0]  o_m0_ack, o_m0_err, o_m1_ack, o_m1_err;
  wire [1:0]  o_mem_read, o_mem_write;
  wire [31:0] o_m0_rd [2];
  wire [31:0] o_m1_rd [2];
  wire [31:0] o_mem_addr [2];
  wire [31:0] o_mem_wdata [2];
  wire [1:0]  o_grant [2];

  int n_chk  = 0;
  int n_pass = 0;

  mem_arbiter #(.PRIORITY_MODE(0), .TIMEOUT(4), .ERR_DATA(32'hDEADBEEF)) u_rr (
    .clk(clk), .reset_n(reset_n),
    .m0_read(m0_read), .m0_write(m0_write), .m0_addr(m0_addr), .m0_write_data(m0_write_data),
    .m0_ack(o_m0_ack[0]), .m0_err(o_m0_err[0]), .m0_read_data(o_m0_rd[0]),
    .m1_read(m1_read), .m1_write(m1_write), .m1_addr(m1_addr), .m1_write_data(m1_write_data),
    .m1_ack(o_m1_ack[0]), .m1_err(o_m1_err[0]), .m1_read_data(o_m1_rd[0]),
    .mem_read(o_mem_read[0]), .mem_write(o_mem_write[0]), .mem_addr(o_mem_addr[0]),
    .mem_write_data(o_mem_wdata[0]), .mem_ack(mem_ack), .mem_read_data(mem_read_data),
    .grant(o_grant[0])
  );

  mem_arbiter #(.PRIORITY_MODE(1), .TIMEOUT(0), .ERR_DATA(32'hDEADBEEF)) u_fp (
    .clk(clk), .reset_n(reset_n),
    .m0_read(m0_read), .m0_write(m0_write), .m0_addr(m0_addr), .m0_write_data(m0_write_data),
    .m0_ack(o_m0_ack[1]), .m0_err(o_m0_err[1]), .m0_read_data(o_m0_rd[1]),
    .m1_read(m1_read), .m1_write(m1_write), .m1_addr(m1_addr), .m1_write_data(m1_write_data),
    .m1_ack(o_m1_ack[1]), .m1_err(o_m1_err[1]), .m1_read_data(o_m1_rd[1]),
    .mem_read(o_mem_read[1]), .mem_write(o_mem_write[1]), .mem_addr(o_mem_addr[1]),
    .mem_write_data(o_mem_wdata[1]), .mem_ack(mem_ack), .mem_read_data(mem_read_data),
    .grant(o_grant[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- transaction-level model (per instance k) ----------------
  // A transaction lives from the grant edge until it is released; age counts
  // cycles since grant, done_age is the age at which the ack is shown.
  bit          e_active [2];
  int          e_owner  [2];
  bit          e_wr     [2];
  logic [31:0] e_addr   [2];
  logic [31:0] e_wdata  [2];
  int          e_age    [2];
  int          e_done   [2];
  bit          e_tmo    [2];
  int          e_last   [2];
  logic [31:0] e_rd0    [2];
  logic [31:0] e_rd1    [2];

  function automatic int timeout_of(input int k);
    return (k == 0) ? 4 : 0;
  endfunction

  task automatic model_reset(input int k);
    e_active[k] = 1'b0; e_owner[k] = 0; e_wr[k] = 1'b0;
    e_addr[k] = '0; e_wdata[k] = '0; e_age[k] = 0; e_done[k] = 0;
    e_tmo[k] = 1'b0; e_last[k] = 1; e_rd0[k] = '0; e_rd1[k] = '0;
  endtask

  task automatic model_finish(input int k, input logic [31:0] data, input bit tmo);
    if (e_owner[k] == 1) e_rd1[k] = data; else e_rd0[k] = data;
    e_done[k] = e_age[k] + 1;
    e_tmo[k]  = tmo;
  endtask

  task automatic model_step(input int k);
    bit p0, p1;
    int w;
    p0 = m0_read | m0_write;
    p1 = m1_read | m1_write;
    if (!e_active[k]) begin
      if (p0 || p1) begin
        if (p0 && p1) w = (k == 1) ? 0 : 1 - e_last[k];
        else          w = p1 ? 1 : 0;
        e_active[k] = 1'b1;
        e_owner[k]  = w;
        e_wr[k]     = (w == 1) ? m1_write : m0_write;
        e_addr[k]   = (w == 1) ? m1_addr : m0_addr;
        e_wdata[k]  = (w == 1) ? m1_write_data : m0_write_data;
        e_age[k]    = 1;
        e_done[k]   = 0;
        e_tmo[k]    = 1'b0;
        e_last[k]   = w;
      end
    end else if (e_done[k] == 0) begin
      if (mem_ack) model_finish(k, mem_read_data, 1'b0);
      else if (timeout_of(k) != 0 && e_age[k] == timeout_of(k)) model_finish(k, 32'hDEADBEEF, 1'b1);
      e_age[k] = e_age[k] + 1;
    end else if (e_age[k] == e_done[k] + 1) begin
      e_active[k] = 1'b0;
    end else begin
      e_age[k] = e_age[k] + 1;
    end
  endtask

  // Model advances on every clock edge and snaps back on reset.
  initial begin
    for (int k = 0; k < 2; k++) model_reset(k);
    forever begin
      @(posedge clk or negedge reset_n);
      for (int k = 0; k < 2; k++) begin
        if (!reset_n) model_reset(k);
        else          model_step(k);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
  endtask

  // Every-cycle comparison of both instances against the model.
  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        bit busy, resp;
        logic [1:0] g;
        busy = e_active[k] && (e_done[k] == 0);
        resp = e_active[k] && (e_done[k] != 0) && (e_age[k] == e_done[k]);
        g    = !e_active[k] ? 2'b00 : ((e_owner[k] == 1) ? 2'b10 : 2'b01);
        chk($sformatf("dut%0d mem_read", k),  32'(o_mem_read[k]),  32'(busy && !e_wr[k]));
        chk($sformatf("dut%0d mem_write", k), 32'(o_mem_write[k]), 32'(busy && e_wr[k]));
        chk($sformatf("dut%0d mem_addr", k),  o_mem_addr[k],  e_addr[k]);
        chk($sformatf("dut%0d mem_wdata", k), o_mem_wdata[k], e_wdata[k]);
        chk($sformatf("dut%0d grant", k),     32'(o_grant[k]),    32'(g));
        chk($sformatf("dut%0d m0_ack", k),    32'(o_m0_ack[k]),   32'(resp && e_owner[k] == 0));
        chk($sformatf("dut%0d m1_ack", k),    32'(o_m1_ack[k]),   32'(resp && e_owner[k] == 1));
        chk($sformatf("dut%0d m0_err", k),    32'(o_m0_err[k]),   32'(resp && e_owner[k] == 0 && e_tmo[k]));
        chk($sformatf("dut%0d m1_err", k),    32'(o_m1_err[k]),   32'(resp && e_owner[k] == 1 && e_tmo[k]));
        chk($sformatf("dut%0d m0_rdata", k),  o_m0_rd[k], e_rd0[k]);
        chk($sformatf("dut%0d m1_rdata", k),  o_m1_rd[k], e_rd1[k]);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_reqs();
    m0_read = 1'b0; m0_write = 1'b0; m1_read = 1'b0; m1_write = 1'b0;
  endtask

  // Directed scenarios with literal expectations, then randomized traffic.
  initial begin
    clear_reqs();
    m0_addr = '0; m0_write_data = '0; m1_addr = '0; m1_write_data = '0;
    mem_ack = 1'b0; mem_read_data = '0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    cyc(2);
    chk("rst mem_read",  32'(o_mem_read),  32'd0);
    chk("rst mem_write", 32'(o_mem_write), 32'd0);
    chk("rst grant",     32'(o_grant[0]),  32'd0);
    chk("rst acks",      32'({o_m0_ack, o_m1_ack}), 32'd0);
    chk("rst m0_rdata",  o_m0_rd[0],  32'd0);
    chk("rst mem_addr",  o_mem_addr[0], 32'd0);
    reset_n = 1'b1;

    // Single read, acked in the third busy cycle.
    m0_read = 1'b1; m0_addr = 32'h10; m0_write_data = 32'h1111_2222;
    cyc(1);
    chk("rd mem_read",  32'(o_mem_read[0]), 32'd1);
    chk("rd mem_addr",  o_mem_addr[0], 32'h10);
    chk("rd grant",     32'(o_grant[0]), 32'd1);
    cyc(2);
    chk("rd mem_read 3rd", 32'(o_mem_read[0]), 32'd1);
    mem_ack = 1'b1; mem_read_data = 32'h1234_5678;
    cyc(1);
    mem_ack = 1'b0; m0_read = 1'b0;
    chk("rd m0_ack",   32'(o_m0_ack[0]), 32'd1);
    chk("rd m0_rdata", o_m0_rd[0], 32'h1234_5678);
    chk("rd m0_err",   32'(o_m0_err[0]), 32'd0);
    chk("rd mem_read drop", 32'(o_mem_read[0]), 32'd0);
    cyc(1);
    chk("rd ack once", 32'(o_m0_ack[0]), 32'd0);
    cyc(1);
    chk("rd grant off", 32'(o_grant[0]), 32'd0);

    // Read and write both set: treated as a write.
    m0_read = 1'b1; m0_write = 1'b1; m0_addr = 32'h20; m0_write_data = 32'hA5A5_A5A5;
    cyc(1);
    chk("rw mem_write", 32'(o_mem_write[0]), 32'd1);
    chk("rw mem_read",  32'(o_mem_read[0]),  32'd0);
    chk("rw wdata",     o_mem_wdata[0], 32'hA5A5_A5A5);
    chk("rw addr",      o_mem_addr[0],  32'h20);
    mem_ack = 1'b1; mem_read_data = 32'h0;
    cyc(1);
    clear_reqs(); mem_ack = 1'b0;
    chk("rw m0_ack", 32'(o_m0_ack[0]), 32'd1);
    cyc(3);

    // Tie held from reset with immediate acks.
    reset_n = 1'b0;
    cyc(1);
    reset_n = 1'b1;
    m0_write = 1'b1; m0_addr = 32'h100; m0_write_data = 32'hCAFE_0000;
    m1_read = 1'b1;  m1_addr = 32'h200;
    mem_ack = 1'b1; mem_read_data = 32'h5555_AAAA;
    for (int t = 0; t < 4; t++) begin
      cyc(1);
      chk($sformatf("tie rr grant %0d", t), 32'(o_grant[0]), (t % 2 == 0) ? 32'd1 : 32'd2);
      chk($sformatf("tie fp grant %0d", t), 32'(o_grant[1]), 32'd1);
      cyc(1);
      chk($sformatf("tie rr owner ack %0d", t),
          32'({o_m1_ack[0], o_m0_ack[0]}), (t % 2 == 0) ? 32'd1 : 32'd2);
      cyc(2);
    end
    clear_reqs(); mem_ack = 1'b0;
    cyc(1);

    // Timeout on requester 1 with the controller silent.
    m1_read = 1'b1; m1_addr = 32'h30;
    cyc(4);
    chk("to mem_read held", 32'(o_mem_read[0]), 32'd1);
    cyc(1);
    chk("to mem_read drop", 32'(o_mem_read[0]), 32'd0);
    chk("to m1_ack",        32'(o_m1_ack[0]), 32'd1);
    chk("to m1_err",        32'(o_m1_err[0]), 32'd1);
    chk("to m1_rdata",      o_m1_rd[0], 32'hDEAD_BEEF);
    chk("to disabled busy", 32'(o_mem_read[1]), 32'd1);
    m1_read = 1'b0;
    cyc(1);
    mem_ack = 1'b1; mem_read_data = 32'h600D_CAFE;
    cyc(1);
    mem_ack = 1'b0;
    chk("late ack ignored",  32'(o_m1_ack[0]), 32'd0);
    chk("late rdata kept",   o_m1_rd[0], 32'hDEAD_BEEF);
    chk("no-timeout m1_ack", 32'(o_m1_ack[1]), 32'd1);
    chk("no-timeout rdata",  o_m1_rd[1], 32'h600D_CAFE);
    m0_read = 1'b1; m0_addr = 32'h44; mem_ack = 1'b1; mem_read_data = 32'h0BAD_F00D;
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 12 && !seen; i++) begin
        cyc(1);
        if (o_m0_ack[0]) seen = 1'b1;
      end
      chk("post-timeout m0_ack seen", 32'(seen), 32'd1);
      chk("post-timeout m0_rdata", o_m0_rd[0], 32'h0BAD_F00D);
      chk("post-timeout m0_err",   32'(o_m0_err[0]), 32'd0);
    end
    clear_reqs(); mem_ack = 1'b0;
    cyc(6);

    // Reset asserted two cycles into a busy transaction.
    mem_ack = 1'b1;
    cyc(3);
    mem_ack = 1'b0;
    m0_read = 1'b1; m0_addr = 32'h50;
    cyc(2);
    #2 reset_n = 1'b0;
    #1;
    chk("mid-rst mem_read", 32'(o_mem_read), 32'd0);
    chk("mid-rst grant",    32'({o_grant[1], o_grant[0]}), 32'd0);
    chk("mid-rst acks",     32'({o_m0_ack, o_m1_ack}), 32'd0);
    cyc(1);
    reset_n = 1'b1;
    m0_read = 1'b0; m0_write = 1'b1; m1_write = 1'b1;
    cyc(1);
    chk("post-rst rr grant", 32'(o_grant[0]), 32'd1);
    chk("post-rst fp grant", 32'(o_grant[1]), 32'd1);
    clear_reqs(); mem_ack = 1'b1;
    cyc(6);

    // Randomized traffic, including silent-controller and held-tie stretches.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        m0_read = 1'($urandom_range(0, 1)); m0_write = 1'($urandom_range(0, 2) == 0);
        m0_addr = $urandom; m0_write_data = $urandom;
      end
      if ($urandom_range(0, 3) == 0) begin
        m1_read = 1'($urandom_range(0, 1)); m1_write = 1'($urandom_range(0, 2) == 0);
        m1_addr = $urandom; m1_write_data = $urandom;
      end
      if (i >= 2000 && i < 2300) begin
        m0_read = 1'b1; m1_write = 1'b1;
      end
      mem_ack = (i >= 1000 && i < 1200) ? 1'b0 : 1'($urandom_range(0, 2) == 0);
      mem_read_data = $urandom;
      cyc(1);
    end
    clear_reqs(); mem_ack = 1'b1;
    cyc(8);
    #2;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
